// File: rtl/ram_stat_accum_if.sv
// Accumulate / clear / read-back signal bundle for the statistics RAM.
interface ram_stat_accum_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64,
  parameter int INC_WIDTH  = 16
);
  logic                  acc_valid;
  logic                  acc_ready;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [INC_WIDTH-1:0]  acc_value;
  logic                  clr_start;
  logic                  clr_busy;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output acc_valid, acc_addr, acc_value, clr_start, rd_en, rd_addr,
    input  acc_ready, clr_busy, rd_valid, rd_data
  );

  modport slave (
    input  acc_valid, acc_addr, acc_value, clr_start, rd_en, rd_addr,
    output acc_ready, clr_busy, rd_valid, rd_data
  );
endinterface

// File: rtl/ram_stat_accum.sv
// Statistics RAM: pipelined read-modify-write counters with forwarding,
// optional saturation, a clear sweep and an independent read-back port.
module ram_stat_accum #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64,
  parameter int INC_WIDTH  = 16,
  parameter bit SATURATE   = 1'b0,
  parameter bit OUT_REG    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  ram_stat_accum_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_a_valid;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic [INC_WIDTH-1:0]  r_a_value;
  logic                  r_b_valid;
  logic [ADDR_WIDTH-1:0] r_b_addr;
  logic [INC_WIDTH-1:0]  r_b_value;
  logic [DATA_WIDTH-1:0] r_b_rdata;
  logic                  r_c_valid;
  logic [ADDR_WIDTH-1:0] r_c_addr;
  logic [DATA_WIDTH-1:0] r_c_data;

  logic                  r_rd_pend;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_run;
  logic                  w_acc_fire;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH:0]   w_sum_full;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_run         = (r_state == S_RUN);
  assign w_acc_fire    = w_run && bus.acc_valid;
  assign bus.acc_ready = w_run;
  assign bus.clr_busy  = !w_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == {ADDR_WIDTH{1'b1}}) r_state <= S_RUN;
        end
        S_RUN: begin
          if (bus.clr_start) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // The op in stage b retires on this same edge, ahead of any clear write.
          if (!r_a_valid) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      r_c_valid <= 1'b0;
    end else begin
      r_a_valid <= w_acc_fire;
      r_b_valid <= r_a_valid;
      r_c_valid <= r_b_valid;
    end
  end

  always_ff @(posedge clk) begin
    r_a_addr  <= bus.acc_addr;
    r_a_value <= bus.acc_value;
    r_b_addr  <= r_a_addr;
    r_b_value <= r_a_value;
    r_c_addr  <= r_b_addr;
    r_c_data  <= w_sum;
    r_rd_addr <= bus.rd_addr;
  end

  // An op two slots back has already landed in the RAM before this op's read,
  // so only the sum retired on the previous edge needs forwarding.
  assign w_old      = (r_c_valid && (r_c_addr == r_b_addr)) ? r_c_data : r_b_rdata;
  assign w_sum_full = {1'b0, w_old} + {{(DATA_WIDTH + 1 - INC_WIDTH){1'b0}}, r_b_value};

  generate
    if (SATURATE) begin : g_sat
      assign w_sum = w_sum_full[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : w_sum_full[DATA_WIDTH-1:0];
    end else begin : g_wrap
      assign w_sum = w_sum_full[DATA_WIDTH-1:0];
    end
  endgenerate

  assign w_we    = !rst && ((r_state == S_CLEAR) || r_b_valid);
  assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : r_b_addr;
  assign w_wdata = (r_state == S_CLEAR) ? '0 : w_sum;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_b_rdata <= r_mem[r_a_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend  <= bus.rd_en;
      r_rd_valid <= r_rd_pend;
      if (r_rd_pend) r_rd_data <= r_mem[r_rd_addr];
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic                  r_rd_valid2;
      logic [DATA_WIDTH-1:0] r_rd_data2;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_valid2 <= 1'b0;
          r_rd_data2  <= '0;
        end else begin
          r_rd_valid2 <= r_rd_valid;
          if (r_rd_valid) r_rd_data2 <= r_rd_data;
        end
      end
      assign bus.rd_valid = r_rd_valid2;
      assign bus.rd_data  = r_rd_data2;
    end else begin : g_noreg
      assign bus.rd_valid = r_rd_valid;
      assign bus.rd_data  = r_rd_data;
    end
  endgenerate
endmodule

// File: tb/tb_ram_stat_accum.sv
// Scoreboard bench: a 64-bit wrap instance plus 8-bit saturate and wrap instances.
module tb_ram_stat_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_stat_accum_if #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .INC_WIDTH(16)) bus ();
  ram_stat_accum_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8),  .INC_WIDTH(8))  sbus ();
  ram_stat_accum_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8),  .INC_WIDTH(8))  wbus ();

  ram_stat_accum #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .INC_WIDTH(16), .SATURATE(1'b0), .OUT_REG(1'b0))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  ram_stat_accum #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .INC_WIDTH(8), .SATURATE(1'b1), .OUT_REG(1'b1))
    u_sat (.clk(clk), .rst(rst), .bus(sbus));
  ram_stat_accum #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .INC_WIDTH(8), .SATURATE(1'b0), .OUT_REG(1'b0))
    u_wrap (.clk(clk), .rst(rst), .bus(wbus));

  logic [63:0] m_main [16];
  logic [7:0]  m_sat  [16];
  logic [7:0]  m_wrap [16];
  logic [63:0] q_main [$];
  logic [7:0]  q_sat  [$];
  logic [7:0]  q_wrap [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] val,
                       input logic clr, input logic re, input logic [3:0] ra);
    bus.acc_valid  = av;  bus.acc_addr  = aa; bus.acc_value  = val;
    bus.clr_start  = clr; bus.rd_en     = re; bus.rd_addr    = ra;
    sbus.acc_valid = av;  sbus.acc_addr = aa; sbus.acc_value = val[7:0];
    sbus.clr_start = clr; sbus.rd_en    = re; sbus.rd_addr   = ra;
    wbus.acc_valid = av;  wbus.acc_addr = aa; wbus.acc_value = val[7:0];
    wbus.clr_start = clr; wbus.rd_en    = re; wbus.rd_addr   = ra;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 4'd0);
    repeat (n) step();
  endtask

  task automatic zero_models();
    for (int i = 0; i < 16; i++) begin
      m_main[i] = '0;
      m_sat[i]  = '0;
      m_wrap[i] = '0;
    end
  endtask

  task automatic acc(input logic [3:0] a, input logic [15:0] v, input logic clr);
    logic       ok;
    logic [8:0] s;
    drive(1'b1, a, v, clr, 1'b0, 4'd0);
    ok = bus.acc_ready;
    step();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 4'd0);
    if (ok) begin
      m_main[a] = m_main[a] + 64'(v);
      s         = {1'b0, m_sat[a]} + {1'b0, v[7:0]};
      m_sat[a]  = s[8] ? 8'hFF : s[7:0];
      m_wrap[a] = m_wrap[a] + v[7:0];
      if (clr) zero_models();
    end
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, a);
    q_main.push_back(m_main[a]);
    q_sat.push_back(m_sat[a]);
    q_wrap.push_back(m_wrap[a]);
    step();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(4);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.clr_busy && n < 200) begin
      step();
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid) begin
        check("main_rd_expected", 64'(q_main.size() != 0), 64'd1);
        if (q_main.size() != 0) check("main_rd", bus.rd_data, q_main.pop_front());
      end
      if (sbus.rd_valid) begin
        check("sat_rd_expected", 64'(q_sat.size() != 0), 64'd1);
        if (q_sat.size() != 0) check("sat_rd", 64'(sbus.rd_data), 64'(q_sat.pop_front()));
      end
      if (wbus.rd_valid) begin
        check("wrap_rd_expected", 64'(q_wrap.size() != 0), 64'd1);
        if (q_wrap.size() != 0) check("wrap_rd", 64'(wbus.rd_data), 64'(q_wrap.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int total;
    zero_models();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    repeat (3) step();
    check("rst_acc_ready", 64'(bus.acc_ready), 64'd0);
    check("rst_clr_busy", 64'(bus.clr_busy), 64'd1);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_data", bus.rd_data, 64'd0);
    check("rst_sat_rd_data", 64'(sbus.rd_data), 64'd0);

    // Initial sweep length, then everything reads zero.
    rst = 1'b0;
    wait_idle(n);
    check("init_clr_len", 64'(n), 64'd16);
    check("run_acc_ready", 64'(bus.acc_ready), 64'd1);
    read_all();

    // Exact read latency after a single accumulate.
    acc(4'd3, 16'd5, 1'b0);
    idle(2);
    rd(4'd3);
    check("lat_main_early", 64'(bus.rd_valid), 64'd0);
    step();
    check("lat_main_valid", 64'(bus.rd_valid), 64'd1);
    check("lat_main_data", bus.rd_data, 64'd5);
    check("lat_sat_early", 64'(sbus.rd_valid), 64'd0);
    step();
    check("lat_sat_valid", 64'(sbus.rd_valid), 64'd1);
    check("lat_sat_data", 64'(sbus.rd_data), 64'd5);
    check("main_rd_pulse", 64'(bus.rd_valid), 64'd0);
    check("main_rd_hold", bus.rd_data, 64'd5);
    idle(3);

    // Distance-1 and distance-2 hazards.
    for (int i = 0; i < 8; i++) acc(4'd7, 16'd1, 1'b0);
    for (int i = 0; i < 6; i++) acc((i % 2 == 0) ? 4'd2 : 4'd5, 16'd10, 1'b0);
    idle(3);
    read_all();

    // Saturate vs wrap on the 8-bit instances.
    for (int i = 0; i < 3; i++) acc(4'd1, 16'h0060, 1'b0);
    idle(3);
    rd(4'd1);
    idle(4);

    // Random dense stream over a few addresses.
    for (int i = 0; i < 60; i++) begin
      acc(4'($urandom_range(0, 3)), 16'($urandom), 1'b0);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(3);
    read_all();

    // Clear while streaming; the coincident accumulate is accepted then wiped.
    for (int i = 0; i < 4; i++) acc(4'd4, 16'(i + 1), (i == 3));
    check("clr_ready_drop", 64'(bus.acc_ready), 64'd0);
    check("clr_busy_high", 64'(bus.clr_busy), 64'd1);
    acc(4'd4, 16'd100, 1'b0);
    wait_idle(n);
    total = n + 1;
    check("clr_busy_len_ok", 64'((total >= 16) && (total <= 18)), 64'd1);
    read_all();

    // Reset in the middle of a sweep restarts it from scratch.
    acc(4'd12, 16'd7, 1'b0);
    idle(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    zero_models();
    wait_idle(n);
    check("rst_sweep_len", 64'(n), 64'd16);
    acc(4'd0, 16'd3, 1'b0);
    idle(3);
    read_all();

    idle(6);
    check("main_q_drained", 64'(q_main.size()), 64'd0);
    check("sat_q_drained", 64'(q_sat.size()), 64'd0);
    check("wrap_q_drained", 64'(q_wrap.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
